// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader: frames WIDTH data bits (plus optional odd parity)
// into a parallel word for the Complement stage, with valid/error pulses.
module serial_byte_loader #(
  parameter int WIDTH     = 8,
  parameter bit PARITY    = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S,
  input  logic             D,
  input  logic             E,
  output logic [WIDTH-1:0] O,
  output logic             V,
  output logic             B,
  output logic             ERR
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic             last_bit;

  // Without parity the final data bit goes straight to O, so the shifted
  // value is needed combinationally.
  always_comb begin
    sreg_nxt = sreg;
    if (MSB_FIRST) sreg_nxt = {sreg[WIDTH-2:0], D};
    else           sreg_nxt = {D, sreg[WIDTH-1:1]};
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign B        = (state == SHIFT) || (state == PAR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      O     <= '0;
      V     <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      V   <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (S) begin
            state <= SHIFT;
            sreg  <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (E) begin
            sreg <= sreg_nxt;
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
              if (PARITY) begin
                state <= PAR;
              end else begin
                state <= DONE;
                O     <= sreg_nxt;
                V     <= 1'b1;
              end
            end
          end
        end
        PAR: begin
          // Odd parity: data bits XOR parity bit must be 1.
          if (E) begin
            state <= DONE;
            if ((^sreg) ^ D) begin
              O <= sreg;
              V <= 1'b1;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: table of frames on the default
// configuration, plus hand sequences for reset, held start and LSB-first/no-parity.
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       s, d, e;
  logic       s2, d2, e2;
  logic [7:0] o, o2;
  logic       v, b, err, v2, b2, err2;

  int nvec = 0;
  int nmis = 0;
  logic [7:0] cur_o;

  always #5 clk = ~clk;

  serial_byte_loader #(.WIDTH(8), .PARITY(1'b1), .MSB_FIRST(1'b1)) dut (
    .CLK(clk), .RST(rst), .S(s), .D(d), .E(e), .O(o), .V(v), .B(b), .ERR(err)
  );

  serial_byte_loader #(.WIDTH(8), .PARITY(1'b0), .MSB_FIRST(1'b0)) dut2 (
    .CLK(clk), .RST(rst), .S(s2), .D(d2), .E(e2), .O(o2), .V(v2), .B(b2), .ERR(err2)
  );

  typedef struct {
    logic [7:0] bits;
    logic       par;
    int         gap;
    logic [7:0] exp_o;
    logic       exp_v;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got {O,V,B,ERR}=%h expected %h", nm, act, exp);
    end
  endtask

  // Sends one frame to the default DUT, MSB first, checking every cycle.
  task automatic frame(input logic [7:0] bits, input logic par, input int gap,
                       input logic hold, input logic [7:0] exp_o,
                       input logic exp_v, input logic exp_err);
    logic [8:0] seq;
    seq = {bits, par};
    s = 1'b1; e = 1'b0;
    tick;
    s = hold;
    chk("start_busy", {o, v, b, err}, {cur_o, 1'b0, 1'b1, 1'b0});
    for (int i = 8; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        e = 1'b0; d = 1'($urandom);
        tick;
        chk("gap_busy", {o, v, b, err}, {cur_o, 1'b0, 1'b1, 1'b0});
      end
      e = 1'b1; d = seq[i];
      tick;
      if (i > 0) chk("bit_busy", {o, v, b, err}, {cur_o, 1'b0, 1'b1, 1'b0});
    end
    chk("done", {o, v, b, err}, {exp_o, exp_v, 1'b0, exp_err});
    cur_o = exp_o;
    e = 1'b0;
    tick;
    chk("back_idle", {o, v, b, err}, {cur_o, 1'b0, 1'b0, 1'b0});
    s = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hF0, 1'b1, 0, 8'hF0, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 3, 8'h55, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b1, 0, 8'hF0, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 1'b0, 0, 8'hF0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 0, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'h01, 1'b0, 2, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 1'b1, 0, 8'hC3, 1'b1, 1'b0};

    rst = 1'b1; s = 1'b0; d = 1'b0; e = 1'b0; s2 = 1'b0; d2 = 1'b0; e2 = 1'b0;
    cur_o = 8'h00;
    tick; tick;
    rst = 1'b0;
    chk("reset_state", {o, v, b, err}, 11'h000);

    // E/D ignored in IDLE without S
    e = 1'b1; d = 1'b1;
    tick;
    chk("idle_ignore_e", {o, v, b, err}, 11'h000);
    e = 1'b0;

    for (int k = 0; k < 8; k++)
      frame(vecs[k].bits, vecs[k].par, vecs[k].gap, 1'b0,
            vecs[k].exp_o, vecs[k].exp_v, vecs[k].exp_err);

    // Reset mid-frame, with S/E asserted alongside RST
    s = 1'b1; tick; s = 1'b0;
    for (int i = 0; i < 4; i++) begin e = 1'b1; d = 1'b1; tick; end
    rst = 1'b1; s = 1'b1; e = 1'b1;
    tick;
    rst = 1'b0; s = 1'b0; e = 1'b0;
    cur_o = 8'h00;
    chk("mid_reset", {o, v, b, err}, 11'h000);
    tick;
    chk("post_reset_idle", {o, v, b, err}, 11'h000);
    frame(8'h22, 1'b1, 0, 1'b0, 8'h22, 1'b1, 1'b0);

    // S held through the frame and DONE: IDLE for one cycle, then SHIFT again
    frame(8'hFF, 1'b1, 0, 1'b1, 8'hFF, 1'b1, 1'b0);
    s = 1'b1;
    tick;
    chk("restart_on_held_s", {o, v, b, err}, {8'hFF, 1'b0, 1'b1, 1'b0});
    s = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    cur_o = 8'h00;
    chk("reset_after_restart", {o, v, b, err}, 11'h000);

    // No parity, LSB first: V 9 cycles after S
    s2 = 1'b1; tick; s2 = 1'b0;
    chk("v2_start", {o2, v2, b2, err2}, {8'h00, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      e2 = 1'b1; d2 = (i >= 4);
      tick;
      if (i < 7) chk("v2_busy", {o2, v2, b2, err2}, {8'h00, 1'b0, 1'b1, 1'b0});
    end
    chk("v2_done_f0", {o2, v2, b2, err2}, {8'hF0, 1'b1, 1'b0, 1'b0});
    e2 = 1'b0;
    tick;
    chk("v2_idle", {o2, v2, b2, err2}, {8'hF0, 1'b0, 1'b0, 1'b0});

    // LSB first with gaps: bits 1,0,1,1,0,0,0,0 -> 8'h0D
    s2 = 1'b1; tick; s2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'h0D;
      e2 = 1'b0; d2 = ~pat[i]; tick;
      e2 = 1'b1; d2 = pat[i]; tick;
      if (i < 7) chk("v2_gap_busy", {o2, v2, b2, err2}, {8'hF0, 1'b0, 1'b1, 1'b0});
    end
    chk("v2_done_0d", {o2, v2, b2, err2}, {8'h0D, 1'b1, 1'b0, 1'b0});
    e2 = 1'b0;
    tick;
    chk("v2_idle2", {o2, v2, b2, err2}, {8'h0D, 1'b0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
Serial-to-parallel front end that feeds the 8-bit Complement stage. It collects WIDTH data bits from a serial line and, optionally, one odd-parity bit. It then presents the assembled word on O, with a one-cycle valid pulse, for the downstream stage's I input. It replaces the switch-driven parallel stimulus used in earlier labs with a framed serial load.

Parameters:
WIDTH, 8, number of data bits per word
PARITY, 1, 1 = one odd-parity bit follows the data bits; 0 = no parity bit
MSB_FIRST, 1, 1 = first data bit received lands in O[WIDTH-1]; 0 = first bit lands in O[0]

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
S  input  1  start strobe; sampled only in IDLE
D  input  1  serial data; sampled on cycles where E=1
E  input  1  bit enable; qualifies D
O  output  WIDTH  last successfully loaded word; drives the Complement I input
V  output  1  one-cycle pulse when O has just been updated with a good word
B  output  1  busy: high while a frame is being received
ERR  output  1  one-cycle pulse when the parity check fails

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: O=0, V=0, B=0, ERR=0, state=IDLE, bit counter=0, shift register=0.
- RST has priority over every other input in the same cycle, including S and E.
- RST mid-frame abandons the frame. All outputs take their reset values on the next edge, and the partial word is discarded.
- FSM states: IDLE, SHIFT, PAR, DONE.
- IDLE:
  - B=0.
  - S=1 moves to SHIFT and clears the shift register and counter.
  - E and D are ignored in IDLE, including in the cycle S is accepted.
- SHIFT:
  - B=1.
  - On each cycle with E=1, D is shifted into the shift register (direction set by MSB_FIRST) and the counter increments.
  - E=0 holds the state; any number of idle gaps is legal.
  - On the cycle the WIDTH-th bit is sampled, move to PAR if PARITY=1, else to DONE.
  - S is ignored.
- PAR:
  - B=1.
  - On the first cycle with E=1, compute the check: XOR of the WIDTH data bits and D.
  - Result 1 means good; result 0 means parity error.
  - Then move to DONE. E=0 holds the state.
- DONE (exactly one cycle):
  - B=0.
  - Good frame: O is loaded with the shift register and V=1.
  - Bad frame: O holds its previous value, ERR=1 and V=0.
  - Next state is IDLE unconditionally. S asserted in DONE is ignored; a new frame needs S in IDLE.
- Latency:
  - V or ERR asserts on the edge after the final sampled bit (data bit if PARITY=0, parity bit if PARITY=1).
  - The new O value is visible in the same cycle as V.
  - The minimum frame is 1 (S) + WIDTH + PARITY + 1 (DONE) cycles from the S cycle to return to IDLE.
- V and ERR are never high together. Neither is ever high outside DONE.
- Outside DONE and reset, O changes on no cycle.
- Counter width is clog2(WIDTH+1). The counter never wraps because the FSM leaves SHIFT at count WIDTH.

Test Plan:
1. Good frame, MSB first: RST, then S=1; send 1,1,1,1,0,0,0,0 with E=1 each cycle, then parity bit D=1. Required: O=8'hF0 and V=1 for exactly one cycle, 10 cycles after S; B high for 9 cycles; ERR=0.
2. Gapped enables: send 0,1,0,1,0,1,0,1 plus parity 1, with E low for 3 cycles between each bit and D toggling randomly while E=0. Required: O=8'h55, one V pulse, ERR=0.
3. Parity error: first load 8'hF0 cleanly. Then send 1,0,1,0,1,0,1,0 with parity bit 0. Required: ERR pulse for one cycle, V=0, O stays 8'hF0.
4. Reset mid-frame: after S and 4 data bits, assert RST for one cycle. Then send a complete frame for 8'h22 with parity 1. Required: all outputs 0 the cycle after RST; the following frame yields O=8'h22 with one V pulse.
5. Ignored starts: hold S=1 throughout a frame for 8'hFF with parity 1, and keep S=1 during DONE. Required: a single V pulse with O=8'hFF. The FSM re-enters SHIFT only if S is still high in the IDLE cycle after DONE.
6. Parameter variant PARITY=0, MSB_FIRST=0: send 0,0,0,0,1,1,1,1. Required: O=8'hF0 and V asserted 9 cycles after S; ERR never asserts.
